// File: rtl/avalon_arb_pkg.sv
// Shared types and default widths for the Avalon-MM upsizer front-end arbiter.
package avalon_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ      = 2;
    localparam int DEF_ADDR_W       = 15;
    localparam int DEF_DATA_W       = 128;
    localparam int DEF_READ_LATENCY = 1;

    // Width of an encoded requester id; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/avalon_upsizer_arbiter_rr.sv
// Combinational round-robin picker: the lowest-indexed request strictly after
// last_id wins, wrapping around to index 0.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_vld
);

    always_comb begin
        grant_id  = '0;
        grant_vld = 1'b0;
        // First pass covers the indices above the pointer, second pass wraps.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req[i] && (i > int'(last_id))) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req[i] && (i <= int'(last_id))) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_vld && (grant_id == ID_W'(i));
        end
    end

endmodule

// File: rtl/avalon_upsizer_arbiter.sv
// Round-robin sharing of the upsizer's 128-bit slave port among NUM_REQ requesters,
// with a registered command stage and a fixed-latency read-return id pipeline.
module avalon_upsizer_arbiter
    import avalon_arb_pkg::*;
#(
    parameter  int NUM_REQ      = DEF_NUM_REQ,
    parameter  int ADDR_W       = DEF_ADDR_W,
    parameter  int DATA_W       = DEF_DATA_W,
    parameter  int READ_LATENCY = DEF_READ_LATENCY,
    localparam int BE_W         = DATA_W / 8,
    localparam int ID_W         = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr_i,
    input  logic [NUM_REQ-1:0]        ReqRead_i,
    input  logic [NUM_REQ-1:0]        ReqWrite_i,
    input  logic [NUM_REQ*BE_W-1:0]   ReqByteEnable_i,
    input  logic [NUM_REQ*DATA_W-1:0] ReqWriteData_i,
    output logic [NUM_REQ-1:0]        ReqWaitReq_o,
    output logic [DATA_W-1:0]         ReqReadData_o,
    output logic [NUM_REQ-1:0]        ReqReadValid_o,
    output logic [ADDR_W-1:0]         DnAddr_o,
    output logic                      DnRead_o,
    output logic                      DnWrite_o,
    output logic [BE_W-1:0]           DnByteEnable_o,
    output logic [DATA_W-1:0]         DnWriteData_o,
    input  logic [DATA_W-1:0]         DnReadData_i,
    input  logic                      DnWaitReq_i,
    output logic                      ProtoErr_o
);

    arb_state_e          state, state_nxt;
    logic [ID_W-1:0]     rr_last;
    logic                proto_err;

    logic [NUM_REQ-1:0]  req_any;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;
    logic                grant_vld;

    logic [ADDR_W-1:0]   win_addr;
    logic [BE_W-1:0]     win_be;
    logic [DATA_W-1:0]   win_wdata;
    logic                win_rd;
    logic                win_wr;

    logic [ADDR_W-1:0]   cmd_addr_p0;
    logic [BE_W-1:0]     cmd_be_p0;
    logic [DATA_W-1:0]   cmd_wdata_p0;
    logic                cmd_rd_p0;
    logic                cmd_wr_p0;
    logic [ID_W-1:0]     cmd_id_p0;

    logic                load;
    logic                accept;
    logic                rd_accept;
    logic                busy;

    logic [READ_LATENCY-1:0] vld_p;
    logic [ID_W-1:0]         id_p [READ_LATENCY];

    assign req_any = ReqRead_i | ReqWrite_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req       (req_any),
        .last_id   (rr_last),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    // Read+write from one requester is issued as a write only.
    always_comb begin
        win_addr  = '0;
        win_be    = '0;
        win_wdata = '0;
        win_rd    = 1'b0;
        win_wr    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_addr  = ReqAddr_i[i*ADDR_W +: ADDR_W];
                win_be    = ReqByteEnable_i[i*BE_W +: BE_W];
                win_wdata = ReqWriteData_i[i*DATA_W +: DATA_W];
                win_wr    = ReqWrite_i[i];
                win_rd    = ReqRead_i[i] & ~ReqWrite_i[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!DnWaitReq_i) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_last   <= ID_W'(NUM_REQ - 1);
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rr_last <= cmd_id_p0;
            end
            if (|(ReqRead_i & ReqWrite_i)) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Stage p0: registered command, qualified by BUSY at the outputs.
    always_ff @(posedge clk) begin
        if (load) begin
            cmd_addr_p0  <= win_addr;
            cmd_be_p0    <= win_be;
            cmd_wdata_p0 <= win_wdata;
            cmd_rd_p0    <= win_rd;
            cmd_wr_p0    <= win_wr;
            cmd_id_p0    <= grant_id;
        end
    end

    assign busy           = (state == BUSY);
    assign DnAddr_o       = busy ? cmd_addr_p0  : '0;
    assign DnByteEnable_o = busy ? cmd_be_p0    : '0;
    assign DnWriteData_o  = busy ? cmd_wdata_p0 : '0;
    assign DnRead_o       = busy & cmd_rd_p0;
    assign DnWrite_o      = busy & cmd_wr_p0;
    assign ProtoErr_o     = proto_err;

    always_comb begin
        ReqWaitReq_o = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            ReqWaitReq_o[i] = !(accept && (cmd_id_p0 == ID_W'(i)));
        end
    end

    assign rd_accept = accept & cmd_rd_p0;

    // Stages p[0..READ_LATENCY-1]: read-return tags aligned with DnReadData_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        id_p[0] <= cmd_id_p0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            id_p[i] <= id_p[i-1];
        end
    end

    assign ReqReadData_o = DnReadData_i;

    always_comb begin
        ReqReadValid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ReqReadValid_o[i] = vld_p[READ_LATENCY-1] && (id_p[READ_LATENCY-1] == ID_W'(i));
        end
    end

endmodule

// File: tb/tb_avalon_upsizer_arbiter.sv
// Directed bench: two arbiter instances (read latency 1 and 3) share one stimulus.
module tb_avalon_upsizer_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [29:0]  req_addr;
    logic [1:0]   req_rd;
    logic [1:0]   req_wr;
    logic [31:0]  req_be;
    logic [255:0] req_wdata;
    logic [127:0] dn_rdata;
    logic         dn_wait;

    logic [1:0]   a_wait, a_rvalid, b_wait, b_rvalid;
    logic [127:0] a_rdata, b_rdata, a_dn_wdata, b_dn_wdata;
    logic [14:0]  a_dn_addr, b_dn_addr;
    logic         a_dn_read, a_dn_write, b_dn_read, b_dn_write;
    logic [15:0]  a_dn_be, b_dn_be;
    logic         a_perr, b_perr;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [127:0] WD0 = {4{32'hAAAA_0000}};
    localparam logic [127:0] WD1 = {4{32'hBBBB_0001}};

    always #5 clk = ~clk;

    avalon_upsizer_arbiter #(.NUM_REQ(2), .ADDR_W(15), .DATA_W(128), .READ_LATENCY(1)) u_a (
        .clk(clk), .rst(rst),
        .ReqAddr_i(req_addr), .ReqRead_i(req_rd), .ReqWrite_i(req_wr),
        .ReqByteEnable_i(req_be), .ReqWriteData_i(req_wdata),
        .ReqWaitReq_o(a_wait), .ReqReadData_o(a_rdata), .ReqReadValid_o(a_rvalid),
        .DnAddr_o(a_dn_addr), .DnRead_o(a_dn_read), .DnWrite_o(a_dn_write),
        .DnByteEnable_o(a_dn_be), .DnWriteData_o(a_dn_wdata),
        .DnReadData_i(dn_rdata), .DnWaitReq_i(dn_wait), .ProtoErr_o(a_perr)
    );

    avalon_upsizer_arbiter #(.NUM_REQ(2), .ADDR_W(15), .DATA_W(128), .READ_LATENCY(3)) u_b (
        .clk(clk), .rst(rst),
        .ReqAddr_i(req_addr), .ReqRead_i(req_rd), .ReqWrite_i(req_wr),
        .ReqByteEnable_i(req_be), .ReqWriteData_i(req_wdata),
        .ReqWaitReq_o(b_wait), .ReqReadData_o(b_rdata), .ReqReadValid_o(b_rvalid),
        .DnAddr_o(b_dn_addr), .DnRead_o(b_dn_read), .DnWrite_o(b_dn_write),
        .DnByteEnable_o(b_dn_be), .DnWriteData_o(b_dn_wdata),
        .DnReadData_i(dn_rdata), .DnWaitReq_i(dn_wait), .ProtoErr_o(b_perr)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_rd = '0;
        req_wr = '0;
        next();
        next();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_addr = '0; req_rd = '0; req_wr = '0;
        req_be = '0; req_wdata = '0; dn_rdata = '0; dn_wait = 1'b1;
        next(); next(); #1;
        check("rst_dn_read", a_dn_read, 0);
        check("rst_dn_addr", a_dn_addr, 0);
        check("rst_wait", a_wait, 2'b11);
        check("rst_rvalid_a", a_rvalid, 0);
        check("rst_rvalid_b", b_rvalid, 0);
        check("rst_perr", a_perr, 0);
        rst = 1'b0;

        // Single read from req0, accepted on the first BUSY cycle.
        next(); req_addr[14:0] = 15'h0004; req_rd = 2'b01; dn_wait = 1'b0; #1;
        check("t1_idle_read", a_dn_read, 0);
        check("t1_idle_wait", a_wait, 2'b11);
        next(); #1;
        check("t1_dn_read", a_dn_read, 1);
        check("t1_dn_addr", a_dn_addr, 15'h0004);
        check("t1_dn_write", a_dn_write, 0);
        check("t1_accept_wait", a_wait, 2'b10);
        next(); req_rd = 2'b00; dn_rdata = {16{8'hA5}}; #1;
        check("t1_read_drop", a_dn_read, 0);
        check("t1_rvalid_a", a_rvalid, 2'b01);
        check("t1_rdata_a", a_rdata, {16{8'hA5}});
        check("t1_wait_after", a_wait, 2'b11);
        check("t1_rvalid_b_early", b_rvalid, 0);
        next(); #1;
        check("t1_rvalid_a_once", a_rvalid, 0);
        check("t1_rvalid_b_early2", b_rvalid, 0);
        next(); #1;
        check("t1_rvalid_b", b_rvalid, 2'b01);
        next(); #1;
        check("t1_rvalid_b_once", b_rvalid, 0);

        // Both requesters hold writes: grants alternate 0,1,0,1 every other cycle.
        do_reset();
        req_addr = {15'h0200, 15'h0100};
        req_be = {16'hFF00, 16'h00FF};
        req_wdata = {WD1, WD0};
        req_wr = 2'b11; dn_wait = 1'b0; #1;
        check("t2_idle_wait", a_wait, 2'b11);
        for (int k = 0; k < 8; k++) begin
            next(); #1;
            if (k % 2 == 0) begin
                if ((k / 2) % 2 == 0) begin
                    check("t2_wait_g0", a_wait, 2'b10);
                    check("t2_addr_g0", a_dn_addr, 15'h0100);
                    check("t2_be_g0", a_dn_be, 16'h00FF);
                    check("t2_wdata_g0", a_dn_wdata, WD0);
                end else begin
                    check("t2_wait_g1", a_wait, 2'b01);
                    check("t2_addr_g1", a_dn_addr, 15'h0200);
                    check("t2_be_g1", a_dn_be, 16'hFF00);
                    check("t2_wdata_g1", a_dn_wdata, WD1);
                end
                check("t2_write_on", a_dn_write, 1);
                check("t2_read_off", a_dn_read, 0);
            end else begin
                check("t2_bubble_wait", a_wait, 2'b11);
                check("t2_bubble_write", a_dn_write, 0);
            end
        end
        req_wr = 2'b00;

        // Downstream stalls five BUSY cycles; accept only on the sixth.
        next(); req_wr = 2'b10; req_addr[29:15] = 15'h0333; dn_wait = 1'b1; #1;
        for (int k = 1; k <= 5; k++) begin
            next(); #1;
            check("t3_stall_write", a_dn_write, 1);
            check("t3_stall_addr", a_dn_addr, 15'h0333);
            check("t3_stall_wait", a_wait, 2'b11);
        end
        next(); dn_wait = 1'b0; #1;
        check("t3_accept_wait", a_wait, 2'b01);
        check("t3_accept_write", a_dn_write, 1);
        next(); req_wr = 2'b00; #1;
        check("t3_done_write", a_dn_write, 0);
        check("t3_done_wait", a_wait, 2'b11);

        // Reads req1 then req0; latency-3 returns keep order.
        next(); req_rd = 2'b10; #1;
        next(); req_rd = 2'b11; #1;
        check("t4_acc1_wait", a_wait, 2'b01);
        check("t4_acc1_addr", a_dn_addr, 15'h0333);
        check("t4_acc1_read", a_dn_read, 1);
        next(); req_rd = 2'b01; #1;
        check("t4_bubble_read", a_dn_read, 0);
        check("t4_rvalid_a1", a_rvalid, 2'b10);
        check("t4_rvalid_b_c2", b_rvalid, 0);
        next(); req_rd = 2'b00; #1;
        check("t4_acc0_wait", a_wait, 2'b10);
        check("t4_acc0_addr", a_dn_addr, 15'h0100);
        check("t4_rvalid_b_c3", b_rvalid, 0);
        next(); dn_rdata = 128'h0C4; #1;
        check("t4_rvalid_b1", b_rvalid, 2'b10);
        check("t4_rdata_b1", b_rdata, 128'h0C4);
        check("t4_rvalid_a0", a_rvalid, 2'b01);
        next(); #1;
        check("t4_rvalid_b_c5", b_rvalid, 0);
        next(); dn_rdata = 128'h0C6; #1;
        check("t4_rvalid_b0", b_rvalid, 2'b01);
        check("t4_rdata_b0", b_rdata, 128'h0C6);
        next(); #1;
        check("t4_rvalid_b_c7", b_rvalid, 0);

        // Reset one cycle after a read accept flushes the in-flight read.
        next(); req_rd = 2'b01; #1;
        next(); #1;
        check("t5_accept_wait", a_wait, 2'b10);
        next(); req_rd = 2'b00; rst = 1'b1; #1;
        check("t5_rvalid_b_c2", b_rvalid, 0);
        next(); rst = 1'b0; #1;
        check("t5_rvalid_b_c3", b_rvalid, 0);
        check("t5_dn_read", a_dn_read, 0);
        check("t5_wait_idle", a_wait, 2'b11);
        next(); #1;
        check("t5_rvalid_b_flushed", b_rvalid, 0);
        next(); #1;
        check("t5_rvalid_a_none", a_rvalid, 0);
        // Reset while stalled in BUSY drops the command.
        req_wr = 2'b01; dn_wait = 1'b1;
        next(); #1;
        check("t5_busy_write", a_dn_write, 1);
        rst = 1'b1;
        next(); rst = 1'b0; req_wr = 2'b00; #1;
        check("t5_drop_write", a_dn_write, 0);
        check("t5_drop_addr", a_dn_addr, 0);
        check("t5_drop_wait", a_wait, 2'b11);

        // Read and write together: issued as a write, protocol error sticks.
        next(); req_rd = 2'b01; req_wr = 2'b01; req_addr[14:0] = 15'h0055; dn_wait = 1'b0; #1;
        next(); #1;
        check("t6_write", a_dn_write, 1);
        check("t6_read", a_dn_read, 0);
        check("t6_addr", a_dn_addr, 15'h0055);
        check("t6_perr", a_perr, 1);
        check("t6_wait", a_wait, 2'b10);
        next(); req_rd = 2'b00; req_wr = 2'b00; #1;
        check("t6_perr_sticky", a_perr, 1);
        check("t6_no_rvalid_a", a_rvalid, 0);
        next(); #1;
        next(); #1;
        check("t6_no_rvalid_b", b_rvalid, 0);
        check("t6_perr_sticky_b", b_perr, 1);
        rst = 1'b1;
        next(); rst = 1'b0; #1;
        check("t6_perr_cleared", a_perr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
